// File: rtl/simple_processor_sequencer.sv
// Program sequencer for the 9-bit simple processor: feeds stored words to DIN/Run,
// paces on Done, counts retired instructions and flags finish or watchdog/format errors.
//
// state  | meaning
// IDLE   | waiting for start after reset
// ISSUE  | Run=1, DIN=mem[pc] for one cycle
// IMM    | DIN=mem[pc+1] (mvi immediate), waiting for Done
// WAIT   | DIN=mem[pc], waiting for Done
// FINISH | program retired, finished=1 until start/Reset
// ERROR  | timeout or malformed mvi, error=1 until start/Reset
module simple_processor_sequencer #(
  parameter int         DEPTH      = 16,
  parameter int         AW         = 4,
  parameter logic [2:0] IMM_OPCODE = 3'b011,
  parameter int         TIMEOUT    = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [8:0]    load_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          Done,
  output logic          Run,
  output logic [8:0]    DIN,
  output logic          busy,
  output logic          finished,
  output logic          error,
  output logic [AW:0]   pc,
  output logic [AW:0]   retired
);

  localparam int          WW      = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_IMM, S_WAIT, S_FINISH, S_ERROR
  } state_t;

  state_t        state, nstate;
  logic [8:0]    mem [DEPTH];
  logic [AW:0]   len_q, pc_q, ret_q;
  logic [WW-1:0] wdog;
  logic [8:0]    din_q;

  logic          busy_int, wr_en, idle_like, start_ok, malformed;
  logic [AW:0]   pc_done, issue_pc, issue_len, pc_plus1;
  logic [AW+1:0] issue_nxt;
  logic [8:0]    issue_word;

  assign busy_int  = (state == S_ISSUE) || (state == S_IMM) || (state == S_WAIT);
  assign idle_like = (state == S_IDLE) || (state == S_FINISH) || (state == S_ERROR);
  assign wr_en     = load_en && !busy_int;
  assign start_ok  = (prog_len != '0) && (prog_len <= LEN_MAX);
  assign pc_plus1  = pc_q + 1'b1;
  assign pc_done   = (state == S_IMM) ? pc_q + 2'd2 : pc_plus1;

  // Word about to be issued; bypass a same-edge write so start+load sees the new word.
  assign issue_pc   = idle_like ? '0 : pc_done;
  assign issue_len  = idle_like ? prog_len : len_q;
  assign issue_word = (wr_en && (load_addr == issue_pc[AW-1:0])) ? load_data
                                                                  : mem[issue_pc[AW-1:0]];
  assign issue_nxt  = {1'b0, issue_pc} + 1'b1;
  assign malformed  = (issue_word[8:6] == IMM_OPCODE) && (issue_nxt >= {1'b0, issue_len});

  always_ff @(posedge Clock) begin
    if (wr_en) mem[load_addr] <= load_data;
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE, S_FINISH, S_ERROR: begin
        if (start) begin
          if (prog_len == '0)          nstate = S_FINISH;
          else if (prog_len > LEN_MAX) nstate = S_ERROR;
          else if (malformed)          nstate = S_ERROR;
          else                         nstate = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem[pc_q[AW-1:0]][8:6] == IMM_OPCODE) nstate = S_IMM;
        else                                      nstate = S_WAIT;
      end
      S_IMM, S_WAIT: begin
        // Done takes priority over a simultaneous watchdog expiry.
        if (Done) begin
          if (pc_done >= len_q) nstate = S_FINISH;
          else if (malformed)   nstate = S_ERROR;
          else                  nstate = S_ISSUE;
        end else if (wdog == WD_LAST) begin
          nstate = S_ERROR;
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      len_q <= '0;
      pc_q  <= '0;
      ret_q <= '0;
      wdog  <= '0;
      din_q <= '0;
    end else begin
      din_q <= DIN;
      case (state)
        S_IDLE, S_FINISH, S_ERROR: begin
          if (start && start_ok) begin
            len_q <= prog_len;
            pc_q  <= '0;
            ret_q <= '0;
          end
        end
        S_ISSUE: wdog <= '0;
        S_IMM, S_WAIT: begin
          if (Done) begin
            pc_q  <= pc_done;
            ret_q <= ret_q + 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Run      = (state == S_ISSUE);
    busy     = busy_int;
    finished = (state == S_FINISH);
    error    = (state == S_ERROR);
    pc       = pc_q;
    retired  = ret_q;
    case (state)
      S_ISSUE, S_WAIT: DIN = mem[pc_q[AW-1:0]];
      S_IMM:           DIN = mem[pc_plus1[AW-1:0]];
      default:         DIN = din_q;
    endcase
  end

endmodule

// File: tb/tb_simple_processor_sequencer.sv
// Directed bench for simple_processor_sequencer with a small processor model that
// pulses Done two cycles after each Run.
module tb_simple_processor_sequencer;

  logic       Clock = 1'b0;
  logic       Reset, load_en, start, Done;
  logic [3:0] load_addr;
  logic [8:0] load_data, DIN;
  logic [4:0] prog_len, pc, retired;
  logic       Run, busy, finished, error;

  int         n_chk = 0;
  int         n_fail = 0;
  logic       model_on = 1'b0;
  int         dly = 0;
  logic [8:0] cap [32];
  int         nrun;

  always #5 Clock = ~Clock;

  simple_processor_sequencer dut (
    .Clock(Clock), .Reset(Reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .prog_len(prog_len), .Done(Done),
    .Run(Run), .DIN(DIN), .busy(busy), .finished(finished), .error(error),
    .pc(pc), .retired(retired)
  );

  // Processor model: Done high in the second cycle after the ISSUE cycle.
  always @(negedge Clock) begin
    if (!model_on) begin
      dly  = 0;
      Done = 1'b0;
    end else if (Run) begin
      dly  = 2;
      Done = 1'b0;
    end else if (dly != 0) begin
      dly  = dly - 1;
      Done = (dly == 0);
    end else begin
      Done = 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int a, input int d);
    load_en   = 1'b1;
    load_addr = 4'(a);
    load_data = 9'(d);
    @(negedge Clock);
    load_en   = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    start    = 1'b1;
    prog_len = 5'(len);
    @(negedge Clock);
    start    = 1'b0;
  endtask

  task automatic run_capture(input int len, output int n);
    bit ended;
    ended = 1'b0;
    n = 0;
    pulse_start(len);
    for (int i = 0; i < 400; i++) begin
      if (Run) begin
        cap[n] = DIN;
        n++;
      end
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      @(negedge Clock);
    end
    if (!ended) check_val("run_bound", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ended;
    ended = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      @(negedge Clock);
    end
    if (!ended) check_val("idle_bound", 32'd0, 32'd1);
  endtask

  logic [9:0] basic_exp [9];

  initial begin
    basic_exp[0] = 10'h2C1; basic_exp[1] = 10'h1F0; basic_exp[2] = 10'h1F0;
    basic_exp[3] = 10'h2D1; basic_exp[4] = 10'h10F; basic_exp[5] = 10'h10F;
    basic_exp[6] = 10'h282; basic_exp[7] = 10'h082; basic_exp[8] = 10'h082;

    Reset = 1'b1; load_en = 1'b0; start = 1'b0;
    load_addr = '0; load_data = '0; prog_len = '0;
    repeat (2) @(negedge Clock);
    check_val("rst_run", Run, 0);
    check_val("rst_din", DIN, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_flags", {finished, error}, 0);
    check_val("rst_pc", pc, 0);
    check_val("rst_retired", retired, 0);
    Reset = 1'b0;
    @(negedge Clock);

    // mvi/sub program
    load_word(0, 9'b011_000_001);
    load_word(1, 9'b111_110_000);
    load_word(2, 9'b011_010_001);
    load_word(3, 9'b100_001_111);
    load_word(4, 9'b010_000_010);
    model_on = 1'b1;
    pulse_start(5);
    for (int i = 0; i < 9; i++) begin
      check_val("basic_run_din", {Run, DIN}, basic_exp[i]);
      @(negedge Clock);
    end
    check_val("basic_finished", finished, 1);
    check_val("basic_busy", busy, 0);
    check_val("basic_retired", retired, 3);
    check_val("basic_pc", pc, 5);
    check_val("basic_din_hold", DIN, 9'h082);

    // watchdog, with word 0 written on the same edge as start
    model_on  = 1'b0;
    load_en   = 1'b1; load_addr = 4'd0; load_data = 9'b010_000_010;
    start     = 1'b1; prog_len = 5'd1;
    @(negedge Clock);
    load_en = 1'b0; start = 1'b0;
    check_val("to_issue", {Run, DIN}, 10'h282);
    repeat (8) @(negedge Clock);
    check_val("to_not_yet", {busy, error}, 2'b10);
    @(negedge Clock);
    check_val("to_error", error, 1);
    check_val("to_run", Run, 0);
    check_val("to_finished", finished, 0);

    // malformed mvi as the last word
    load_word(0, 9'b011_000_001);
    pulse_start(1);
    check_val("mal_error", error, 1);
    check_val("mal_run", Run, 0);
    check_val("mal_din", DIN, 9'h082);
    check_val("mal_retired", retired, 0);

    // prog_len boundaries
    pulse_start(0);
    check_val("len0_flags", {finished, error}, 2'b10);
    pulse_start(17);
    check_val("len17_flags", {finished, error}, 2'b01);
    for (int i = 0; i < 16; i++) load_word(i, 9'h040 + i);
    model_on = 1'b1;
    run_capture(16, nrun);
    check_val("len16_issues", nrun, 16);
    check_val("len16_retired", retired, 16);
    check_val("len16_pc", pc, 16);
    check_val("len16_finished", finished, 1);
    check_val("len16_first", cap[0], 9'h040);
    check_val("len16_last", cap[15], 9'h04F);

    // load_en and start while busy are ignored
    pulse_start(2);
    @(negedge Clock);
    load_en = 1'b1; load_addr = 4'd1; load_data = 9'h1FF;
    start = 1'b1; prog_len = 5'd0;
    @(negedge Clock);
    load_en = 1'b0; start = 1'b0;
    wait_idle(50);
    check_val("ign_finished", finished, 1);
    check_val("ign_retired", retired, 2);
    run_capture(2, nrun);
    check_val("ign_issues", nrun, 2);
    check_val("ign_mem", cap[1], 9'h041);

    // reset during IMM
    load_word(0, 9'b011_000_001);
    load_word(1, 9'b111_110_000);
    pulse_start(2);
    @(negedge Clock);
    check_val("rmid_imm_din", {Run, DIN}, 10'h1F0);
    Reset = 1'b1;
    @(negedge Clock);
    check_val("rmid_run_din", {Run, DIN}, 0);
    check_val("rmid_busy_flags", {busy, finished, error}, 0);
    check_val("rmid_pc_ret", {pc, retired}, 0);
    Reset = 1'b0;
    @(negedge Clock);
    run_capture(2, nrun);
    check_val("rerun_issues", nrun, 1);
    check_val("rerun_word", cap[0], 9'h0C1);
    check_val("rerun_retired", retired, 1);
    check_val("rerun_pc", pc, 2);
    check_val("rerun_din", DIN, 9'h1F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
